sba_arbiter: RTL
================

Name: sba_arbiter

Overview:
Two-master arbiter for the SBA simple bus. It shares the single slave-side bus (BRAM, CLINT, PLIC, UART, SPI, SRAM decode) between the CPU (master 0) and a DMA/bus-mastering peripheral (master 1). It sits between the masters and the existing address decode/mux. Arbitration is round-robin, and a lock input keeps atomic (LR/SC/AMO) sequences indivisible.

Parameters:
- TIMEOUT, 255: cycles without ack before the watchdog aborts a transfer (used only with SBA_ARB_TIMEOUT_EN).
- TO_W, 8: timeout counter width; TIMEOUT must be less than 2^TO_W.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_m0_stb / i_m1_stb  in  1  master request strobe; held with stable addr/we/data until the master's ack
- i_m0_addr / i_m1_addr  in  32  byte address
- i_m0_we / i_m1_we  in  4  byte write enables
- i_m0_dat_w / i_m1_dat_w  in  32  write data
- i_m0_lock  in  1  CPU atomic lock: while high, grant stays with master 0 across transfers
- o_m0_ack / o_m1_ack  out  1  per-master ack, single-cycle pulse
- o_m0_dat_r / o_m1_dat_r  out  32  read data, valid when that master's ack is high
- o_stb  out  1  bus strobe to the decoder
- o_addr  out  32  bus address
- o_we  out  4  bus byte enables
- o_dat_w  out  32  bus write data
- i_ack  in  1  bus ack from the decode mux
- i_dat_r  in  32  bus read data
- o_grant  out  2  one-hot current grant; 00 when idle
- o_err  out  1  sticky timeout flag (always 0 without the optional feature)

Behaviour:
- Reset (async): state=IDLE, last=1 (master 0 wins the first tie), o_grant=00, o_err=0. All outputs are 0: o_stb=0, o_m*_ack=0, o_m*_dat_r=0, o_addr/o_we/o_dat_w=0.
- State machine states: IDLE, BUS0, BUS1, HOLD0.
- IDLE:
  - Only m0 requesting -> BUS0. Only m1 requesting -> BUS1.
  - Both requesting -> the master not equal to `last`.
  - i_m0_lock=1 -> BUS0 whenever m0 requests, regardless of `last`.
  - The decision is registered: o_stb rises the cycle after the request is seen, so arbitration costs 1 cycle.
- BUSn:
  - o_stb=1 and o_addr/o_we/o_dat_w are driven combinationally from master n (mux selected by registered grant).
  - On i_ack=1: o_mn_ack=1 and o_mn_dat_r=i_dat_r in the same cycle; set last=n.
  - Next state: HOLD0 if n=0 and i_m0_lock=1, else IDLE.
- HOLD0:
  - o_stb=0, grant stays 01, m1 is blocked.
  - m0 stb -> BUS0 next cycle. i_m0_lock falls -> IDLE.
- Ack gating:
  - i_ack is forwarded only in BUSn and only to master n.
  - i_ack seen in IDLE/HOLD0 (late registered acks, e.g. BRAM) is discarded.
  - o_stb deasserts the cycle after the accepted ack (state is already IDLE), so a stale decoder ack cannot complete a second transfer.
- o_m*_dat_r: registered, updated only on that master's ack, otherwise held. The ack itself is combinational from i_ack.
- Request dropped mid-transfer: a master dropping stb before ack is illegal. The arbiter stays in BUSn driving the latched master's current signals until ack.
- Back-to-back: after an ack, the minimum gap before the next o_stb is 1 cycle (IDLE).
- Fairness: with both masters continuously requesting and no lock, grants strictly alternate 0,1,0,1.
- Reset mid-transfer: immediate return to IDLE, o_stb=0, the pending ack is never delivered.

Optional Feature:
- SBA_ARB_TIMEOUT_EN defined:
  - A TO_W-bit counter clears on entering BUSn and increments each BUSn cycle without i_ack.
  - When it reaches TIMEOUT: o_mn_ack=1 with o_mn_dat_r=0, o_err set (sticky until reset), state -> IDLE. A lock-held timeout goes to IDLE (lock released).
- Undefined: no counter; o_err tied 0; a BUSn state with no ack waits forever.

Decomposition:
- Shared package sba_pkg:
  - state encoding (IDLE=2'd0, BUS0=2'd1, BUS1=2'd2, HOLD0=2'd3)
  - SBA width constants (ADDR_W=32, DATA_W=32, WE_W=4)
- Sub-module sba_rr_pick: combinational 2-way round-robin picker (inputs req[1:0], last, lock0; output one-hot pick). It is reusable if the master count grows.
- The FSM, muxes and watchdog stay in sba_arbiter.

Test Plan:
- Single m0 read of 0x00001000, slave acks 1 cycle after stb with 0xDEADBEEF -> o_stb high 1 cycle after i_m0_stb; o_m0_ack pulse; o_m0_dat_r=0xDEADBEEF; o_m1_ack never high.
- m0 and m1 request simultaneously after reset and hold requests for 4 transfers -> grant order 0,1,0,1; each bus address matches the granted master (0x80000000 vs 0x10000000).
- i_m0_lock=1 over two m0 transfers while m1 requests continuously -> m1 not granted until the cycle after lock falls; state passes through HOLD0.
- Extra i_ack injected in IDLE (BRAM-style late ack) -> no o_m*_ack, state stays IDLE.
- i_rst asserted while in BUS1 with no ack -> o_stb=0 and o_grant=00 asynchronously; no ack pulse after reset release.
- SBA_ARB_TIMEOUT_EN, TIMEOUT=8, slave never acks m1 -> o_m1_ack high after 8 BUS1 cycles with o_m1_dat_r=0; o_err=1 and remains set.

Source files
------------

// File: rtl/sba_pkg.sv
// Shared definitions for the SBA two-master arbiter: FSM state encoding and bus widths.
package sba_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WE_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS0  = 2'd1,
    BUS1  = 2'd2,
    HOLD0 = 2'd3
  } sba_state_e;

endpackage

// File: rtl/sba_rr_pick.sv
// Combinational 2-way round-robin picker; lock0 pins the pick to master 0 while it requests.
module sba_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock0,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    // master 0 wins when locked, alone, or when master 1 was served last
    if (req[0] && (lock0 || !req[1] || last)) begin
      pick = 2'b01;
    end else if (req[1]) begin
      pick = 2'b10;
    end
  end

endmodule

// File: rtl/sba_arbiter.sv
// Round-robin arbiter sharing the SBA slave bus between CPU (m0) and DMA (m1), with atomic lock.
// Optional watchdog abort of unacked transfers is enabled by defining SBA_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant; registered arbitration decision taken here
// BUS0  | master 0 owns the bus, waiting for i_ack
// BUS1  | master 1 owns the bus, waiting for i_ack
// HOLD0 | master 0 holds the lock between transfers, bus idle, m1 blocked
module sba_arbiter
  import sba_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_stb,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [WE_W-1:0]   i_m0_we,
  input  logic [DATA_W-1:0] i_m0_dat_w,
  input  logic              i_m0_lock,
  output logic              o_m0_ack,
  output logic [DATA_W-1:0] o_m0_dat_r,
  input  logic              i_m1_stb,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [WE_W-1:0]   i_m1_we,
  input  logic [DATA_W-1:0] i_m1_dat_w,
  output logic              o_m1_ack,
  output logic [DATA_W-1:0] o_m1_dat_r,
  output logic              o_stb,
  output logic [ADDR_W-1:0] o_addr,
  output logic [WE_W-1:0]   o_we,
  output logic [DATA_W-1:0] o_dat_w,
  input  logic              i_ack,
  input  logic [DATA_W-1:0] i_dat_r,
  output logic [1:0]        o_grant,
  output logic              o_err
);

  sba_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] m0_dat_r_q, m0_dat_r_d;
  logic [DATA_W-1:0] m1_dat_r_q, m1_dat_r_d;
  logic [1:0]        pick;
  logic              to_hit;

  // Misconfiguration leaves a conspicuously named scope in the elaborated hierarchy.
  if (TIMEOUT >= (1 << TO_W)) begin : g_timeout_exceeds_counter
  end

  sba_rr_pick u_pick (
    .req   ({i_m1_stb, i_m0_stb}),
    .last  (last_q),
    .lock0 (i_m0_lock),
    .pick  (pick)
  );

`ifdef SBA_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;

  always_comb begin
    to_cnt_d = '0;
    err_d    = err_q;
    to_hit   = 1'b0;
    if ((state_q == BUS0 || state_q == BUS1) && !i_ack) begin
      if (to_cnt_q == TO_W'(TIMEOUT)) begin
        to_hit = 1'b1;
        err_d  = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign to_hit = 1'b0;
  assign o_err  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    m0_dat_r_d = m0_dat_r_q;
    m1_dat_r_d = m1_dat_r_q;
    o_stb      = 1'b0;
    o_addr     = '0;
    o_we       = '0;
    o_dat_w    = '0;
    o_m0_ack   = 1'b0;
    o_m1_ack   = 1'b0;
    o_grant    = 2'b00;
    case (state_q)
      IDLE: begin
        if (pick[0]) begin
          state_d = BUS0;
        end else if (pick[1]) begin
          state_d = BUS1;
        end
      end
      BUS0: begin
        o_stb   = 1'b1;
        o_addr  = i_m0_addr;
        o_we    = i_m0_we;
        o_dat_w = i_m0_dat_w;
        o_grant = 2'b01;
        if (i_ack || to_hit) begin
          o_m0_ack   = 1'b1;
          m0_dat_r_d = i_ack ? i_dat_r : '0;
          last_d     = 1'b0;
          // a watchdog abort releases the lock rather than parking in HOLD0
          state_d    = (i_m0_lock && !to_hit) ? HOLD0 : IDLE;
        end
      end
      BUS1: begin
        o_stb   = 1'b1;
        o_addr  = i_m1_addr;
        o_we    = i_m1_we;
        o_dat_w = i_m1_dat_w;
        o_grant = 2'b10;
        if (i_ack || to_hit) begin
          o_m1_ack   = 1'b1;
          m1_dat_r_d = i_ack ? i_dat_r : '0;
          last_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      HOLD0: begin
        o_grant = 2'b01;
        if (!i_m0_lock) begin
          state_d = IDLE;
        end else if (i_m0_stb) begin
          state_d = BUS0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data follows i_dat_r during the ack cycle and is held from the register afterwards.
  assign o_m0_dat_r = m0_dat_r_d;
  assign o_m1_dat_r = m1_dat_r_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      m0_dat_r_q <= '0;
      m1_dat_r_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      m0_dat_r_q <= m0_dat_r_d;
      m1_dat_r_q <= m1_dat_r_d;
    end
  end

endmodule
